// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
//
// Passive front end of an I2C slave. It synchronises the raw SCL/SDA pins
// into the FPGA_clk domain, detects START / repeated START and STOP
// conditions, and tracks the slave-address phase of each transfer for an
// external address decoder.
//
// Parameters
//   SYNC_STAGES      synchroniser depth on each raw bus line (2..4)
//
// Ports
//   FPGA_clk         system clock, rising edge
//   rst              asynchronous, active-high reset
//   scl_in, sda_in   raw asynchronous I2C pins
//   bit_count_enable one-cycle pulse from the decoder: advance bit_count
//   decode_done      one-cycle pulse from the decoder: compare finished
//   selected         decoder match flag, meaningful only with decode_done
//   SCL, SDA         synchronised bus lines (last synchroniser stage)
//   SCL_prev         SCL delayed by one FPGA_clk
//   enable           decoder enable, high in the ADDR phase
//   bit_count        address bit under comparison (0 = MSB), saturates at 6
//   start_det        one-cycle START / repeated-START pulse
//   stop_det         one-cycle STOP pulse
//   addr_match       high while this slave is addressed
//   bus_busy         high between START and STOP
// ---------------------------------------------------------------------------
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       FPGA_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       bit_count_enable,
  input  logic       decode_done,
  input  logic       selected,
  output logic       SCL,
  output logic       SCL_prev,
  output logic       SDA,
  output logic       enable,
  output logic [2:0] bit_count,
  output logic       start_det,
  output logic       stop_det,
  output logic       addr_match,
  output logic       bus_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADDR     = 2'd1,
    SELECTED = 2'd2,
    IGNORE   = 2'd3
  } state_t;

  localparam logic [2:0] BIT_COUNT_MAX = 3'd6;

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   start_cond_s;
  logic                   stop_cond_s;

  state_t                 state_r;
  logic [2:0]             bit_count_r;
  logic                   enable_r;
  logic                   addr_match_r;
  logic                   bus_busy_r;
  logic                   start_det_r;
  logic                   stop_det_r;

  // Synchroniser chains and one-cycle history of the synchronised lines.
  // Reset loads the idle bus level (1) everywhere so that releasing reset
  // cannot look like an SDA falling edge with SCL high.
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
      scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
      sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
    end
  end

  // SDA edges only count as bus conditions when SCL has been high for two
  // consecutive samples; anything else is an ordinary data transition.
  assign start_cond_s = scl_sync_r[SYNC_STAGES-1] & scl_prev_r &
                        sda_prev_r & ~sda_sync_r[SYNC_STAGES-1];
  assign stop_cond_s  = scl_sync_r[SYNC_STAGES-1] & scl_prev_r &
                        ~sda_prev_r & sda_sync_r[SYNC_STAGES-1];

  // Transfer-phase FSM. Outputs are registered alongside the state so they
  // never depend combinationally on inputs. START/STOP are checked first so
  // they override any decoder pulse arriving in the same cycle.
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      bit_count_r  <= 3'd0;
      enable_r     <= 1'b0;
      addr_match_r <= 1'b0;
      bus_busy_r   <= 1'b0;
      start_det_r  <= 1'b0;
      stop_det_r   <= 1'b0;
    end else begin
      start_det_r <= start_cond_s;
      stop_det_r  <= stop_cond_s;

      if (start_cond_s) begin
        // START or repeated START: always restart the address phase.
        state_r      <= ADDR;
        bit_count_r  <= 3'd0;
        enable_r     <= 1'b1;
        addr_match_r <= 1'b0;
        bus_busy_r   <= 1'b1;
      end else if (stop_cond_s) begin
        state_r      <= IDLE;
        bit_count_r  <= 3'd0;
        enable_r     <= 1'b0;
        addr_match_r <= 1'b0;
        bus_busy_r   <= 1'b0;
      end else begin
        case (state_r)
          ADDR: begin
            // Saturate instead of wrapping so a stray extra pulse cannot
            // point the decoder back at the MSB.
            if (bit_count_enable && (bit_count_r < BIT_COUNT_MAX)) begin
              bit_count_r <= bit_count_r + 3'd1;
            end else begin
              bit_count_r <= bit_count_r;
            end

            if (decode_done) begin
              enable_r   <= 1'b0;
              bus_busy_r <= 1'b1;
              if (selected) begin
                state_r      <= SELECTED;
                addr_match_r <= 1'b1;
              end else begin
                state_r      <= IGNORE;
                addr_match_r <= 1'b0;
              end
            end else begin
              state_r      <= ADDR;
              enable_r     <= 1'b1;
              addr_match_r <= 1'b0;
              bus_busy_r   <= 1'b1;
            end
          end

          SELECTED: begin
            // Decoder pulses are meaningless here; wait for START/STOP.
            state_r      <= SELECTED;
            enable_r     <= 1'b0;
            addr_match_r <= 1'b1;
            bus_busy_r   <= 1'b1;
          end

          IGNORE: begin
            state_r      <= IGNORE;
            enable_r     <= 1'b0;
            addr_match_r <= 1'b0;
            bus_busy_r   <= 1'b1;
          end

          IDLE: begin
            state_r      <= IDLE;
            enable_r     <= 1'b0;
            addr_match_r <= 1'b0;
            bus_busy_r   <= 1'b0;
          end

          default: begin
            // Unreachable encoding: recover to a quiet bus.
            state_r      <= IDLE;
            bit_count_r  <= 3'd0;
            enable_r     <= 1'b0;
            addr_match_r <= 1'b0;
            bus_busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SCL        = scl_sync_r[SYNC_STAGES-1];
  assign SDA        = sda_sync_r[SYNC_STAGES-1];
  assign SCL_prev   = scl_prev_r;
  assign enable     = enable_r;
  assign bit_count  = bit_count_r;
  assign start_det  = start_det_r;
  assign stop_det   = stop_det_r;
  assign addr_match = addr_match_r;
  assign bus_busy   = bus_busy_r;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_monitor
//
// Directed bench for i2c_bus_monitor. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_i2c_bus_monitor;

  localparam int S = 2;

  logic       FPGA_clk = 1'b0;
  logic       rst;
  logic       scl_in;
  logic       sda_in;
  logic       bit_count_enable;
  logic       decode_done;
  logic       selected;
  logic       SCL;
  logic       SCL_prev;
  logic       SDA;
  logic       enable;
  logic [2:0] bit_count;
  logic       start_det;
  logic       stop_det;
  logic       addr_match;
  logic       bus_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  i2c_bus_monitor #(.SYNC_STAGES(S)) dut (
    .FPGA_clk         (FPGA_clk),
    .rst              (rst),
    .scl_in           (scl_in),
    .sda_in           (sda_in),
    .bit_count_enable (bit_count_enable),
    .decode_done      (decode_done),
    .selected         (selected),
    .SCL              (SCL),
    .SCL_prev         (SCL_prev),
    .SDA              (SDA),
    .enable           (enable),
    .bit_count        (bit_count),
    .start_det        (start_det),
    .stop_det         (stop_det),
    .addr_match       (addr_match),
    .bus_busy         (bus_busy)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge FPGA_clk);
    #1;
  endtask

  // Drive both lines and wait long enough for any resulting pulse to pass.
  task automatic bus(input logic s, input logic d);
    scl_in = s;
    sda_in = d;
    repeat (S + 2) tick();
  endtask

  // START from an idle bus (SCL=1, SDA=1).
  task automatic do_start();
    sda_in = 1'b0;
    repeat (S + 2) tick();
  endtask

  // From SCL=1/SDA=0 bring SDA high under SCL low, then raise SCL.
  task automatic prep_rep_start();
    bus(1'b0, 1'b0);
    bus(1'b0, 1'b1);
    bus(1'b1, 1'b1);
  endtask

  task automatic pulse_bce();
    bit_count_enable = 1'b1;
    tick();
    bit_count_enable = 1'b0;
    tick();
  endtask

  task automatic pulse_decode(input logic sel);
    decode_done = 1'b1;
    selected    = sel;
    tick();
    decode_done = 1'b0;
    selected    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scl_in = 1'b0;
    sda_in = 1'b0;
    bit_count_enable = 1'b0;
    decode_done = 1'b0;
    selected = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({SCL, SDA, SCL_prev} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_lines: got %b expected 111", {SCL, SDA, SCL_prev});
    end
    tests_run++;
    if ({enable, start_det, stop_det, addr_match, bus_busy} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000",
               {enable, start_det, stop_det, addr_match, bus_busy});
    end
    tests_run++;
    if (bit_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_bit_count: got %0d expected 0", bit_count);
    end
    scl_in = 1'b1;
    sda_in = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests_run++;
      if ({start_det, stop_det, bus_busy} !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_release cycle %0d: got %b expected 000", k,
                 {start_det, stop_det, bus_busy});
      end
    end
  endtask

  task automatic test_start();
    logic exp_b;
    sda_in = 1'b0;
    for (int k = 1; k <= S + 3; k++) begin
      tick();
      exp_b = (k == S + 1);
      tests_run++;
      if (start_det !== exp_b) begin
        tests_failed++;
        $display("FAIL start_timing cycle %0d: got %b expected %b", k, start_det, exp_b);
      end
      if (k == S - 1) begin
        tests_run++;
        if (SDA !== 1'b1) begin
          tests_failed++;
          $display("FAIL sda_latency_early: got %b expected 1", SDA);
        end
      end
      if (k == S) begin
        tests_run++;
        if (SDA !== 1'b0) begin
          tests_failed++;
          $display("FAIL sda_latency: got %b expected 0", SDA);
        end
      end
      if (k == S + 1) begin
        tests_run++;
        if ({enable, bus_busy, addr_match, bit_count} !== 6'b110_000) begin
          tests_failed++;
          $display("FAIL start_state: got en=%b busy=%b match=%b bc=%0d expected 1 1 0 0",
                   enable, bus_busy, addr_match, bit_count);
        end
      end
    end
    bus(1'b1, 1'b1);
  endtask

  task automatic test_bit_count();
    logic [2:0] exp_bc;
    do_start();
    for (int i = 1; i <= 7; i++) begin
      pulse_bce();
      exp_bc = (i > 6) ? 3'd6 : 3'(i);
      tests_run++;
      if (bit_count !== exp_bc) begin
        tests_failed++;
        $display("FAIL bit_count pulse %0d: got %0d expected %0d", i, bit_count, exp_bc);
      end
    end
    bus(1'b1, 1'b1);
    tests_run++;
    if ({bus_busy, bit_count} !== 4'b0_000) begin
      tests_failed++;
      $display("FAIL bit_count_stop: got busy=%b bc=%0d expected 0 0", bus_busy, bit_count);
    end
  endtask

  task automatic test_select();
    logic exp_b;
    do_start();
    pulse_decode(1'b1);
    tests_run++;
    if ({addr_match, enable, bus_busy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL select: got match=%b en=%b busy=%b expected 1 0 1",
               addr_match, enable, bus_busy);
    end
    pulse_decode(1'b0);
    pulse_bce();
    tests_run++;
    if ({addr_match, bit_count} !== 4'b1_000) begin
      tests_failed++;
      $display("FAIL select_hold: got match=%b bc=%0d expected 1 0", addr_match, bit_count);
    end
    sda_in = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      tick();
      exp_b = (k == S + 1);
      tests_run++;
      if ({stop_det, start_det} !== {exp_b, 1'b0}) begin
        tests_failed++;
        $display("FAIL stop_timing cycle %0d: got stop=%b start=%b expected %b 0",
                 k, stop_det, start_det, exp_b);
      end
      if (k == S + 1) begin
        tests_run++;
        if ({addr_match, bus_busy, enable} !== 3'b000) begin
          tests_failed++;
          $display("FAIL stop_state: got match=%b busy=%b en=%b expected 0 0 0",
                   addr_match, bus_busy, enable);
        end
      end
    end
  endtask

  task automatic test_ignore();
    do_start();
    pulse_bce();
    pulse_bce();
    pulse_decode(1'b0);
    tests_run++;
    if ({bus_busy, addr_match, enable, bit_count} !== 6'b100_010) begin
      tests_failed++;
      $display("FAIL ignore: got busy=%b match=%b en=%b bc=%0d expected 1 0 0 2",
               bus_busy, addr_match, enable, bit_count);
    end
    pulse_bce();
    tests_run++;
    if (bit_count !== 3'd2) begin
      tests_failed++;
      $display("FAIL ignore_bce: got %0d expected 2", bit_count);
    end
    prep_rep_start();
    sda_in = 1'b0;
    repeat (S + 1) tick();
    tests_run++;
    if ({start_det, enable, addr_match, bit_count} !== 6'b110_000) begin
      tests_failed++;
      $display("FAIL rep_start: got start=%b en=%b match=%b bc=%0d expected 1 1 0 0",
               start_det, enable, addr_match, bit_count);
    end
    bus(1'b1, 1'b1);
  endtask

  task automatic test_data_toggle();
    bus(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      sda_in = ~sda_in;
      for (int k = 0; k < 3; k++) begin
        tick();
        tests_run++;
        if ({start_det, stop_det, bus_busy} !== 3'b000) begin
          tests_failed++;
          $display("FAIL data_toggle %0d/%0d: got start=%b stop=%b busy=%b expected 0 0 0",
                   i, k, start_det, stop_det, bus_busy);
        end
      end
    end
    bus(1'b1, 1'b1);
    // Repeated START coinciding with decoder pulses: START must win.
    do_start();
    pulse_bce();
    pulse_bce();
    prep_rep_start();
    sda_in = 1'b0;
    repeat (S) tick();
    decode_done = 1'b1;
    selected = 1'b1;
    bit_count_enable = 1'b1;
    tick();
    decode_done = 1'b0;
    selected = 1'b0;
    bit_count_enable = 1'b0;
    tests_run++;
    if ({start_det, enable, addr_match, bit_count} !== 6'b110_000) begin
      tests_failed++;
      $display("FAIL start_priority: got start=%b en=%b match=%b bc=%0d expected 1 1 0 0",
               start_det, enable, addr_match, bit_count);
    end
    tick();
    tests_run++;
    if ({enable, addr_match} !== 2'b10) begin
      tests_failed++;
      $display("FAIL start_priority_after: got en=%b match=%b expected 1 0", enable, addr_match);
    end
    bus(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_start();
    pulse_bce();
    pulse_bce();
    pulse_bce();
    pulse_decode(1'b1);
    tests_run++;
    if ({addr_match, bit_count} !== 4'b1_011) begin
      tests_failed++;
      $display("FAIL mid_setup: got match=%b bc=%0d expected 1 3", addr_match, bit_count);
    end
    rst = 1'b1;
    scl_in = 1'b0;
    sda_in = 1'b0;
    #1;
    tests_run++;
    if ({SCL, SDA, SCL_prev, enable, start_det, stop_det, addr_match, bus_busy, bit_count}
        !== 11'b111_00000_000) begin
      tests_failed++;
      $display("FAIL mid_reset: got %b expected 11100000000",
               {SCL, SDA, SCL_prev, enable, start_det, stop_det, addr_match, bus_busy, bit_count});
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= S + 4; k++) begin
      tick();
      tests_run++;
      if ({start_det, stop_det, bus_busy, enable} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL mid_release cycle %0d: got %b expected 0000", k,
                 {start_det, stop_det, bus_busy, enable});
      end
    end
    bus(1'b1, 1'b0);
    bus(1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_start();
    test_bit_count();
    test_select();
    test_ignore();
    test_data_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_bus_monitor.md
I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops on each raw bus line (legal range 2..4).
REQ-002 SHALL have port FPGA_clk, input, 1 bit: system clock; all logic sits on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port scl_in, input, 1 bit: raw, asynchronous I2C SCL pin.
REQ-005 SHALL have port sda_in, input, 1 bit: raw, asynchronous I2C SDA pin.
REQ-006 SHALL have port bit_count_enable, input, 1 bit: single-cycle pulse from the address decoder that advances bit_count.
REQ-007 SHALL have port decode_done, input, 1 bit: address decoder finished (pulse).
REQ-008 SHALL have port selected, input, 1 bit: address decoder match; valid only with decode_done.
REQ-009 SHALL have port SCL, output, 1 bit: synchronised SCL (last sync stage).
REQ-010 SHALL have port SCL_prev, output, 1 bit: SCL delayed by one FPGA_clk.
REQ-011 SHALL have port SDA, output, 1 bit: synchronised SDA.
REQ-012 SHALL have port enable, output, 1 bit: address decoder enable.
REQ-013 SHALL have port bit_count, output, 3 bits: index of the address bit under comparison (0 = MSB).
REQ-014 SHALL have port start_det, output, 1 bit: one-cycle START/repeated-START pulse.
REQ-015 SHALL have port stop_det, output, 1 bit: one-cycle STOP pulse.
REQ-016 SHALL have port addr_match, output, 1 bit: held high while this slave is addressed.
REQ-017 SHALL have port bus_busy, output, 1 bit: high between START and STOP.

Function
REQ-018 SHALL pass scl_in and sda_in each through SYNC_STAGES flops; SCL and SDA SHALL be the final stages (latency SYNC_STAGES cycles).
REQ-019 SHALL register SCL into SCL_prev and SDA into an internal SDA_prev every cycle.
REQ-020 SHALL detect START when SCL=1, SCL_prev=1, SDA_prev=1 and SDA=0, and SHALL assert start_det the following cycle for exactly one cycle.
REQ-021 SHALL detect STOP when SCL=1, SCL_prev=1, SDA_prev=0 and SDA=1, and SHALL assert stop_det the following cycle for exactly one cycle.
REQ-022 SHALL ignore SDA changes while SCL or SCL_prev is 0, because these are data transitions.
REQ-023 SHALL implement FSM states IDLE, ADDR, SELECTED and IGNORE.
REQ-024 SHALL, from any state on a START detection, enter ADDR and clear bit_count to 0; this covers repeated START.
REQ-025 SHALL, from any state on a STOP detection, enter IDLE and clear bit_count.
REQ-026 SHALL, in ADDR, increment bit_count by 1 on each bit_count_enable pulse; bit_count SHALL saturate at 6 with no wrap to 0.
REQ-027 SHALL, in ADDR, move to SELECTED on decode_done=1 with selected=1, and to IGNORE on decode_done=1 with selected=0.
REQ-028 SHALL remain in SELECTED or IGNORE until START or STOP; bit_count_enable and decode_done SHALL be ignored outside ADDR.
REQ-029 SHALL give a START or STOP detection priority over decode_done and bit_count_enable in the same cycle.
REQ-030 SHALL drive enable=1 only in ADDR, addr_match=1 only in SELECTED, and bus_busy=1 in ADDR, SELECTED and IGNORE.
REQ-031 SHALL drive enable, addr_match and bus_busy from registered state, with no combinational path from inputs.

Reset
REQ-032 SHALL, while rst=1, force all sync flops, SCL, SCL_prev, SDA and SDA_prev to 1 (bus idle), so that no false START occurs on release.
REQ-033 SHALL, while rst=1, force state to IDLE and drive bit_count=0 and enable, start_det, stop_det, addr_match and bus_busy to 0.
REQ-034 SHALL, on rst asserted mid-transaction, abort immediately and return to IDLE with no start_det or stop_det pulse on release.

Verification
REQ-035 SHALL cover: SDA 1->0 with SCL held 1 -> start_det one cycle, SYNC_STAGES+1 cycles after the SDA edge; enable=1, bit_count=0.
REQ-036 SHALL cover: START, then 6 bit_count_enable pulses -> bit_count 0..6 and stays 6 on a 7th pulse.
REQ-037 SHALL cover: START, then decode_done=1 with selected=1 -> addr_match=1 and enable=0 next cycle; a STOP -> stop_det pulse, IDLE, addr_match=0.
REQ-038 SHALL cover: START, then decode_done=1 with selected=0 -> IGNORE, bus_busy=1, addr_match=0; a repeated START -> ADDR, bit_count=0.
REQ-039 SHALL cover: SDA toggles while SCL=0 -> no start_det or stop_det; START and decode_done detected in the same cycle -> ADDR wins.
REQ-040 SHALL cover: rst pulse while in SELECTED with bit_count=3 -> all outputs at reset values; no detection pulse after release.
